mem_rsp: RTL and testbench
==========================

// Module: mem_rsp
// PURPOSE
//  Memory-side responder for the core's load/store/fetch request port.
//  Accepts one request per cycle over a valid/ready handshake and performs it on an internal synchronous SRAM.
//  Returns exactly one in-order response per accepted request through a small response FIFO with backpressure.
//  Sits between the pipeline's memory-access initiator and the storage array.
// PARAMETERS
//  DATA_W     24  data word width (bits)
//  ADDR_W     10  word address width; SRAM holds 2**ADDR_W words
//  RSP_DEPTH  4   response FIFO entries, power of two, >= 2
// PORTS
//  iw_clk        in   1       clock, all state on rising edge
//  iw_rst        in   1       reset, synchronous, active-high
//  iw_req_valid  in   1       request present
//  ow_req_ready  out  1       request can be accepted this cycle
//  iw_req_we     in   1       1 = write, 0 = read
//  iw_req_addr   in   ADDR_W  word address
//  iw_req_wdata  in   DATA_W  write data (ignored for reads)
//  ow_rsp_valid  out  1       response at FIFO head
//  iw_rsp_ready  in   1       initiator consumes response
//  ow_rsp_we     out  1       echo of the request's we
//  ow_rsp_data   out  DATA_W  read: SRAM word; write: data written
// BEHAVIOUR
//  - Single clock iw_clk; iw_rst synchronous active-high.
//  - Reset: FIFO rd/wr pointers, count and stage-1 valid go to 0.
//    ow_rsp_valid=0, ow_rsp_we=0, ow_rsp_data=0, ow_req_ready=1 in the first cycle after reset.
//    SRAM contents are not cleared.
//  - Accept: req fires on an edge where iw_req_valid && ow_req_ready.
//  - ow_req_ready = (count + s1_valid) < RSP_DEPTH.
//    Computed from registered state only; no combinational path from iw_rsp_ready or iw_req_valid.
//  - Stage 1 (edge of acceptance, cycle C):
//    write: mem[addr] <= wdata; s1 captures we=1, data=wdata.
//    read: s1 captures we=0, data=mem[addr] (old contents).
//    s1_valid <= fire.
//  - Stage 2 (edge ending C+1): if s1_valid, push {we,data} into the FIFO.
//  - Latency: accepted in cycle C -> ow_rsp_valid first high in cycle C+2 if the FIFO was empty.
//  - Throughput: 1 req/cycle sustained while iw_rsp_ready=1.
//  - Pop: on an edge with ow_rsp_valid && iw_rsp_ready. Output is the FIFO head; head is stable while ow_rsp_valid && !iw_rsp_ready.
//  - Simultaneous push and pop: count unchanged; both pointers advance.
//  - Pointers wrap modulo RSP_DEPTH.
//  - The FIFO never overflows: the credit check counts the in-flight stage-1 entry.
//  - Pop when empty is impossible (ow_rsp_valid=0).
//  - Ordering: responses leave in acceptance order.
//    Read after write to the same address in a later cycle returns the new data.
//  - Reset mid-operation: in-flight s1 entry and all FIFO entries are discarded, with no response emitted for them.
//    SRAM writes already committed remain.
//  - iw_req_* values are don't-care when iw_req_valid=0. Requests not accepted have no effect.
// CONFIGURATION
//  MEM_RSP_STATS_EN defined adds ports:
//    ow_rd_cnt  out 16  accepted reads
//    ow_wr_cnt  out 16  accepted writes
//    ow_stall_cnt out 16  cycles with iw_req_valid && !ow_req_ready
//    All three saturate at 16'hFFFF and reset to 0.
//  MEM_RSP_STATS_EN undefined: these ports and counters are absent; all other behaviour is identical.
// TESTING
//  1. Reset: iw_rst=1 for 2 cycles -> ow_rsp_valid=0, ow_req_ready=1, ow_rsp_data=0.
//  2. Write 0x00ABCD to addr 0x005, then read addr 0x005, rsp_ready=1:
//     -> rsp{we=1,data=0x00ABCD} in C+2, then rsp{we=0,data=0x00ABCD} in C+3.
//  3. 8 back-to-back reads of addrs 0..7 (preloaded 0x10+i), rsp_ready=1:
//     -> req_ready stays 1; 8 consecutive responses 0x10..0x17 in order.
//  4. rsp_ready=0, issue reads:
//     -> exactly 4 accepted; req_ready=0 thereafter.
//     Raise rsp_ready -> 4 responses in order, then req_ready=1.
//  5. Reset with 3 responses queued -> ow_rsp_valid=0 next cycle; none of the 3 responses ever appears.
//  6. With MEM_RSP_STATS_EN: 3 reads, 2 writes, 5 stalled cycles -> rd_cnt=3, wr_cnt=2, stall_cnt=5.
//     Saturation: force 65536 writes -> wr_cnt holds 0xFFFF.

Source files
------------

// File: rtl/mem_rsp.sv
// mem_rsp: memory-side responder with an internal synchronous SRAM.
// Requests are accepted over valid/ready. Each accepted request goes through a one-cycle
// SRAM stage (s1) and is then pushed into a small response FIFO with backpressure.
// Optional macro MEM_RSP_STATS_EN adds saturating read/write/stall counters.
module mem_rsp #(
  parameter int unsigned DATA_W    = 24,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic              iw_clk,
  input  logic              iw_rst,
  input  logic              iw_req_valid,
  output logic              ow_req_ready,
  input  logic              iw_req_we,
  input  logic [ADDR_W-1:0] iw_req_addr,
  input  logic [DATA_W-1:0] iw_req_wdata,
  output logic              ow_rsp_valid,
  input  logic              iw_rsp_ready,
  output logic              ow_rsp_we,
  output logic [DATA_W-1:0] ow_rsp_data
`ifdef MEM_RSP_STATS_EN
  ,
  output logic [15:0]       ow_rd_cnt,
  output logic [15:0]       ow_wr_cnt,
  output logic [15:0]       ow_stall_cnt
`endif
);

  localparam int unsigned PTR_W     = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned MEM_WORDS = 1 << ADDR_W;
  localparam int unsigned ENT_W     = DATA_W + 1;

  logic [DATA_W-1:0] mem_q [MEM_WORDS];
  logic [ENT_W-1:0]  fifo_q [RSP_DEPTH];

  logic              s1_valid_q;
  logic              s1_we_q;
  logic [DATA_W-1:0] s1_data_q;

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              fire;
  logic              push;
  logic              pop;
  logic              rsp_valid;
  logic [ENT_W-1:0]  head;

  // Credit check counts the in-flight s1 entry so the FIFO can never overflow.
  assign ow_req_ready = (count_q + CNT_W'(s1_valid_q)) < CNT_W'(RSP_DEPTH);
  assign fire         = iw_req_valid & ow_req_ready;
  assign push         = s1_valid_q;
  assign rsp_valid    = (count_q != '0);
  assign pop          = rsp_valid & iw_rsp_ready;
  assign head         = fifo_q[rd_ptr_q];

  // Head is gated so outputs read zero whenever nothing is queued (including after reset).
  assign ow_rsp_valid = rsp_valid;
  assign ow_rsp_we    = rsp_valid & head[DATA_W];
  assign ow_rsp_data  = rsp_valid ? head[DATA_W-1:0] : '0;

  // Next-state for FIFO pointers and occupancy.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state: pointers, occupancy and s1 valid.
  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      s1_valid_q <= fire;
    end
  end

  // SRAM access and s1 payload capture; read returns the pre-write contents.
  always_ff @(posedge iw_clk) begin
    if (fire && !iw_rst) begin
      if (iw_req_we) mem_q[iw_req_addr] <= iw_req_wdata;
      s1_we_q   <= iw_req_we;
      s1_data_q <= iw_req_we ? iw_req_wdata : mem_q[iw_req_addr];
    end
  end

  // FIFO storage; occupancy tracking decides which entries are live.
  always_ff @(posedge iw_clk) begin
    if (push) fifo_q[wr_ptr_q] <= {s1_we_q, s1_data_q};
  end

`ifdef MEM_RSP_STATS_EN
  logic [15:0] rd_cnt_q, wr_cnt_q, stall_cnt_q;

  assign ow_rd_cnt    = rd_cnt_q;
  assign ow_wr_cnt    = wr_cnt_q;
  assign ow_stall_cnt = stall_cnt_q;

  // Saturating request statistics.
  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (fire && !iw_req_we && rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
      if (fire &&  iw_req_we && wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
      if (iw_req_valid && !ow_req_ready && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_rsp.sv
// tb_mem_rsp: scoreboard bench for mem_rsp; the stimulus side queues expected responses
// from a plain memory-array model, a separate monitor pops and compares on each handshake.
module tb_mem_rsp;

  localparam int unsigned DATA_W = 24;
  localparam int unsigned ADDR_W = 10;

  logic              iw_clk = 1'b0;
  logic              iw_rst;
  logic              iw_req_valid;
  logic              ow_req_ready;
  logic              iw_req_we;
  logic [ADDR_W-1:0] iw_req_addr;
  logic [DATA_W-1:0] iw_req_wdata;
  logic              ow_rsp_valid;
  logic              iw_rsp_ready;
  logic              ow_rsp_we;
  logic [DATA_W-1:0] ow_rsp_data;
`ifdef MEM_RSP_STATS_EN
  logic [15:0]       ow_rd_cnt, ow_wr_cnt, ow_stall_cnt;
`endif

  mem_rsp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RSP_DEPTH(4)) dut (
    .iw_clk       (iw_clk),
    .iw_rst       (iw_rst),
    .iw_req_valid (iw_req_valid),
    .ow_req_ready (ow_req_ready),
    .iw_req_we    (iw_req_we),
    .iw_req_addr  (iw_req_addr),
    .iw_req_wdata (iw_req_wdata),
    .ow_rsp_valid (ow_rsp_valid),
    .iw_rsp_ready (iw_rsp_ready),
    .ow_rsp_we    (ow_rsp_we),
    .ow_rsp_data  (ow_rsp_data)
`ifdef MEM_RSP_STATS_EN
    ,
    .ow_rd_cnt    (ow_rd_cnt),
    .ow_wr_cnt    (ow_wr_cnt),
    .ow_stall_cnt (ow_stall_cnt)
`endif
  );

  always #5 iw_clk = ~iw_clk;

  int checks = 0;
  int errors = 0;

  logic [DATA_W:0]   exp_q [$];
  logic [DATA_W-1:0] model_mem [1 << ADDR_W];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every response handshake must match the oldest queued expectation.
  always @(negedge iw_clk) begin
    logic [DATA_W:0] e;
    if (!iw_rst && ow_rsp_valid && iw_rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got we=%0b data=0x%0h, required no response (t=%0t)",
                 ow_rsp_we, ow_rsp_data, $time);
      end else begin
        e = exp_q.pop_front();
        check("rsp_we", 32'(ow_rsp_we), 32'(e[DATA_W]));
        check("rsp_data", 32'(ow_rsp_data), 32'(e[DATA_W-1:0]));
      end
    end
  end

  // One request attempt for one cycle; called just after a rising edge.
  task automatic issue(input logic we, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] data, output logic acc, output logic rv);
    iw_req_valid = 1'b1;
    iw_req_we    = we;
    iw_req_addr  = addr;
    iw_req_wdata = data;
    @(negedge iw_clk);
    acc = ow_req_ready;
    rv  = ow_rsp_valid;
    if (acc) begin
      if (we) begin
        exp_q.push_back({1'b1, data});
        model_mem[addr] = data;
      end else begin
        exp_q.push_back({1'b0, model_mem[addr]});
      end
    end
    @(posedge iw_clk);
    #1;
  endtask

  task automatic idle(input int n);
    iw_req_valid = 1'b0;
    iw_req_we    = 1'($urandom);
    iw_req_addr  = ADDR_W'($urandom);
    iw_req_wdata = DATA_W'($urandom);
    repeat (n) @(posedge iw_clk);
    #1;
  endtask

  task automatic drain(input string name);
    bit done = 0;
    iw_req_valid = 1'b0;
    iw_rsp_ready = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge iw_clk);
      #1;
      if (exp_q.size() == 0 && !ow_rsp_valid) done = 1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_drain_timeout: got %0d pending, required 0", name, exp_q.size());
    end
    @(posedge iw_clk);
    #1;
  endtask

  initial begin
    logic acc, rv;
    int   n_acc;

    iw_rst       = 1'b1;
    iw_req_valid = 1'b0;
    iw_req_we    = 1'b0;
    iw_req_addr  = '0;
    iw_req_wdata = '0;
    iw_rsp_ready = 1'b1;

    // Reset for two cycles, then outputs must be idle and accepting.
    repeat (2) @(posedge iw_clk);
    #1;
    iw_rst = 1'b0;
    @(negedge iw_clk);
    check("reset_rsp_valid", 32'(ow_rsp_valid), 32'd0);
    check("reset_req_ready", 32'(ow_req_ready), 32'd1);
    check("reset_rsp_data", 32'(ow_rsp_data), 32'd0);
    check("reset_rsp_we", 32'(ow_rsp_we), 32'd0);
    @(posedge iw_clk);
    #1;

    // Write then read the same address back to back; check first-response latency.
    issue(1'b1, 10'h005, 24'h00ABCD, acc, rv);
    check("t2_wr_acc", 32'(acc), 32'd1);
    issue(1'b0, 10'h005, 24'h0, acc, rv);
    check("t2_rd_acc", 32'(acc), 32'd1);
    check("t2_valid_c1", 32'(rv), 32'd0);
    iw_req_valid = 1'b0;
    @(negedge iw_clk);
    check("t2_valid_c2", 32'(ow_rsp_valid), 32'd1);
    check("t2_we_c2", 32'(ow_rsp_we), 32'd1);
    @(negedge iw_clk);
    check("t2_valid_c3", 32'(ow_rsp_valid), 32'd1);
    check("t2_rd_c3", 32'({ow_rsp_we, ow_rsp_data}), 32'({1'b0, 24'h00ABCD}));
    @(posedge iw_clk);
    #1;
    drain("t2");

    // Preload 0..7 with 0x10+i, then 8 back-to-back reads at full throughput.
    for (int i = 0; i < 8; i++) issue(1'b1, ADDR_W'(i), DATA_W'(32'h10 + i), acc, rv);
    drain("t3_pre");
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      issue(1'b0, ADDR_W'(i), 24'h0, acc, rv);
      n_acc += int'(acc);
    end
    check("t3_all_accepted", 32'(n_acc), 32'd8);
    drain("t3");

    // Backpressure: only RSP_DEPTH requests get credit.
    iw_rsp_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 7; i++) begin
      issue(1'b0, ADDR_W'(i), 24'h0, acc, rv);
      n_acc += int'(acc);
    end
    check("t4_accepted", 32'(n_acc), 32'd4);
    iw_req_valid = 1'b0;
    @(negedge iw_clk);
    check("t4_ready_low", 32'(ow_req_ready), 32'd0);
    @(posedge iw_clk);
    #1;
    drain("t4");
    @(negedge iw_clk);
    check("t4_ready_back", 32'(ow_req_ready), 32'd1);
    @(posedge iw_clk);
    #1;

    // Reset with 2 queued + 1 in flight: none of them may surface.
    iw_rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue(1'b0, ADDR_W'(i), 24'h0, acc, rv);
    iw_req_valid = 1'b0;
    iw_rst = 1'b1;
    exp_q.delete();
    @(posedge iw_clk);
    #1;
    iw_rst = 1'b0;
    @(negedge iw_clk);
    check("t5_rsp_valid", 32'(ow_rsp_valid), 32'd0);
    check("t5_req_ready", 32'(ow_req_ready), 32'd1);
    check("t5_rsp_data", 32'(ow_rsp_data), 32'd0);
    @(posedge iw_clk);
    #1;
    iw_rsp_ready = 1'b1;
    idle(10);

`ifdef MEM_RSP_STATS_EN
    // 3 reads, 2 writes, 5 stalled cycles since the reset above.
    iw_rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue(1'b0, ADDR_W'(i), 24'h0, acc, rv);
    issue(1'b1, 10'h020, 24'h111111, acc, rv);
    check("t6_w0_acc", 32'(acc), 32'd1);
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 10'h021, 24'h222222, acc, rv);
      check("t6_stall_acc", 32'(acc), 32'd0);
    end
    iw_rsp_ready = 1'b1;
    issue(1'b1, 10'h021, 24'h222222, acc, rv);
    check("t6_stall5_acc", 32'(acc), 32'd0);
    issue(1'b1, 10'h021, 24'h222222, acc, rv);
    check("t6_w1_acc", 32'(acc), 32'd1);
    drain("t6");
    check("t6_rd_cnt", 32'(ow_rd_cnt), 32'd3);
    check("t6_wr_cnt", 32'(ow_wr_cnt), 32'd2);
    check("t6_stall_cnt", 32'(ow_stall_cnt), 32'd5);
`endif

    // Randomized traffic on a small address window with random backpressure.
    for (int i = 0; i < 16; i++) issue(1'b1, ADDR_W'(i), DATA_W'($urandom), acc, rv);
    drain("rnd_pre");
    for (int i = 0; i < 600; i++) begin
      iw_rsp_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) != 0)
        issue(1'($urandom), ADDR_W'($urandom_range(0, 15)), DATA_W'($urandom), acc, rv);
      else
        idle(1);
    end
    drain("rnd");

`ifdef MEM_RSP_STATS_EN
    // Write counter saturates.
    for (int i = 0; i < 65536; i++)
      issue(1'b1, ADDR_W'($urandom_range(0, 15)), DATA_W'(i), acc, rv);
    drain("sat");
    check("sat_wr_cnt", 32'(ow_wr_cnt), 32'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
